// File: rtl/pal_line_inserter_if.sv
// pal_line_inserter_if: VDG sync inputs and padding-window outputs of the
// PAL line inserter.
//   nHS, nFS   VDG horizontal / field sync (active low, asynchronous to Clk)
//   Line24     high while a padding window is open
//   VClkPulse  one-Clk pulse at the end of each synthetic line
//   nHSOut     composite-side horizontal sync
//   PadCount   synthetic lines completed in the current window
//   Overlap    sticky: field sync arrived while the top window was open
interface pal_line_inserter_if;
    logic       nHS;
    logic       nFS;
    logic       Line24;
    logic       VClkPulse;
    logic       nHSOut;
    logic [4:0] PadCount;
    logic       Overlap;

    // master: VDG / interposer side; slave: the inserter itself
    modport master (
        output nHS, nFS,
        input  Line24, VClkPulse, nHSOut, PadCount, Overlap
    );
    modport slave (
        input  nHS, nFS,
        output Line24, VClkPulse, nHSOut, PadCount, Overlap
    );
endinterface

// File: rtl/pal_line_inserter.sv
// pal_line_inserter: stretches a 262-line VDG field to PAL 312-line timing by
// opening two windows of PAD_LINES synthetic lines per field: one at the
// bottom, triggered by the nFS falling edge, and one at the top, opened
// TOP_DELAY nHS falling edges after nFS rises. Inside a window it drives
// Line24, a synthetic nHSOut, and one VClkPulse per synthetic line.
// Ports:
//   Clk    system clock, rising edge
//   Reset  synchronous, active-high
//   bus    pal_line_inserter_if.slave (nHS/nFS in, window outputs out)
module pal_line_inserter #(
    parameter int unsigned LINE_CLKS = 912,
    parameter int unsigned HS_CLKS   = 67,
    parameter int unsigned PAD_LINES = 25,
    parameter int unsigned TOP_DELAY = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    pal_line_inserter_if.slave bus
);

    localparam int unsigned CNT_W = 12;
    localparam int unsigned PAD_W = 5;
    localparam int unsigned DLY_W = 8;

    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(LINE_CLKS - 1);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HS_CLKS);
    localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_LINES);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(TOP_DELAY - 1);

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        BOT_PAD  = 2'd1,
        WAIT_TOP = 2'd2,
        TOP_PAD  = 2'd3
    } state_e;

    logic             nhs_s1_q, nhs_s2_q, nhs_h_q;
    logic             nfs_s1_q, nfs_s2_q, nfs_h_q;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] line_cnt_q,  line_cnt_d;
    logic [PAD_W-1:0] pad_cnt_q,   pad_cnt_d;
    logic [DLY_W-1:0] dly_cnt_q,   dly_cnt_d;
    logic             rise_seen_q, rise_seen_d;
    logic             line24_q,    line24_d;
    logic             vclk_q,      vclk_d;
    logic             nhs_out_q,   nhs_out_d;
    logic             overlap_q,   overlap_d;

    logic             hs_fall_c;
    logic             fs_fall_c;
    logic             fs_rise_c;
    logic             in_pad_c;

    // Two-flop synchronisers plus a history flop; idle level of both syncs is high
    always_ff @(posedge Clk) begin
        if (Reset) begin
            nhs_s1_q <= 1'b1;
            nhs_s2_q <= 1'b1;
            nhs_h_q  <= 1'b1;
            nfs_s1_q <= 1'b1;
            nfs_s2_q <= 1'b1;
            nfs_h_q  <= 1'b1;
        end else begin
            nhs_s1_q <= bus.nHS;
            nhs_s2_q <= nhs_s1_q;
            nhs_h_q  <= nhs_s2_q;
            nfs_s1_q <= bus.nFS;
            nfs_s2_q <= nfs_s1_q;
            nfs_h_q  <= nfs_s2_q;
        end
    end

    assign hs_fall_c = nhs_h_q & ~nhs_s2_q;
    assign fs_fall_c = nfs_h_q & ~nfs_s2_q;
    assign fs_rise_c = ~nfs_h_q & nfs_s2_q;

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ACTIVE;
            line_cnt_q  <= '0;
            pad_cnt_q   <= '0;
            dly_cnt_q   <= '0;
            rise_seen_q <= 1'b0;
            line24_q    <= 1'b0;
            vclk_q      <= 1'b0;
            nhs_out_q   <= 1'b1;
            overlap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            rise_seen_q <= rise_seen_d;
            line24_q    <= line24_d;
            vclk_q      <= vclk_d;
            nhs_out_q   <= nhs_out_d;
            overlap_q   <= overlap_d;
        end
    end

    // Next state; outputs are derived from the next-state counter values so the
    // registered Line24/nHSOut/VClkPulse line up with the line counter itself.
    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        rise_seen_d = rise_seen_q;
        overlap_d   = overlap_q;
        line24_d    = 1'b0;
        vclk_d      = 1'b0;
        nhs_out_d   = nhs_s2_q;
        in_pad_c    = 1'b0;

        case (state_q)
            ACTIVE: begin
                if (fs_fall_c) begin
                    state_d    = BOT_PAD;
                    line_cnt_d = '0;
                    pad_cnt_d  = '0;
                end
            end

            BOT_PAD, TOP_PAD: begin
                if ((state_q == TOP_PAD) && fs_fall_c) begin
                    // New field arrived before the top window finished: restart as bottom window
                    overlap_d  = 1'b1;
                    state_d    = BOT_PAD;
                    line_cnt_d = '0;
                    pad_cnt_d  = '0;
                end else if (line_cnt_q == LAST_CLK) begin
                    line_cnt_d = '0;
                    if (pad_cnt_q >= PAD_LAST) begin
                        state_d     = (state_q == BOT_PAD) ? WAIT_TOP : ACTIVE;
                        dly_cnt_d   = '0;
                        rise_seen_d = 1'b0;
                    end
                end else begin
                    line_cnt_d = line_cnt_q + CNT_W'(1);
                end
            end

            WAIT_TOP: begin
                if (fs_fall_c) begin
                    state_d    = BOT_PAD;
                    line_cnt_d = '0;
                    pad_cnt_d  = '0;
                end else if (fs_rise_c) begin
                    dly_cnt_d   = '0;
                    rise_seen_d = 1'b1;
                end else if (hs_fall_c && rise_seen_q) begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                    if (dly_cnt_q == DLY_LAST) begin
                        state_d    = TOP_PAD;
                        line_cnt_d = '0;
                        pad_cnt_d  = '0;
                    end
                end
            end

            default: begin
                state_d = ACTIVE;
            end
        endcase

        in_pad_c = (state_d == BOT_PAD) || (state_d == TOP_PAD);

        // Synthetic line timebase inside a window
        if (in_pad_c) begin
            line24_d  = 1'b1;
            nhs_out_d = (line_cnt_d >= HS_END);
            if (line_cnt_d == LAST_CLK) begin
                vclk_d = 1'b1;
                if (pad_cnt_d < PAD_LAST) begin
                    pad_cnt_d = pad_cnt_d + PAD_W'(1);
                end
            end
        end
    end

    assign bus.Line24    = line24_q;
    assign bus.VClkPulse = vclk_q;
    assign bus.nHSOut    = nhs_out_q;
    assign bus.PadCount  = pad_cnt_q;
    assign bus.Overlap   = overlap_q;

endmodule

// File: tb/tb_pal_line_inserter.sv
// tb_pal_line_inserter: directed bench for pal_line_inserter.
// DUT a: default timing. DUT b: 64/8/1 parameter sweep. DUT c: short lines,
// TOP_DELAY=2, for overlap/abort and mid-window reset.
module tb_pal_line_inserter;

    typedef struct packed {
        logic       line24;
        logic       vclk;
        logic       nhsout;
        logic [4:0] pad;
        logic       ovl;
    } obs_t;

    typedef struct {
        string       name;
        int unsigned dut;
        int unsigned wait_n;
        logic        rst;
        logic        nhs;
        logic        nfs;
        obs_t        exp;
        obs_t        msk;
    } vec_t;

    localparam obs_t M_ALL = 9'h1FF;
    localparam obs_t M_L24 = 9'h100;
    localparam obs_t M_VC  = 9'h080;
    localparam obs_t M_NHS = 9'h040;
    localparam obs_t M_OVL = 9'h001;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst     [3];
    logic nhs_drv [3];
    logic nfs_drv [3];
    obs_t obs     [3];

    int n_vec  = 0;
    int n_fail = 0;

    pal_line_inserter_if if_a ();
    pal_line_inserter_if if_b ();
    pal_line_inserter_if if_c ();

    assign if_a.nHS = nhs_drv[0];
    assign if_a.nFS = nfs_drv[0];
    assign if_b.nHS = nhs_drv[1];
    assign if_b.nFS = nfs_drv[1];
    assign if_c.nHS = nhs_drv[2];
    assign if_c.nFS = nfs_drv[2];

    assign obs[0] = {if_a.Line24, if_a.VClkPulse, if_a.nHSOut, if_a.PadCount, if_a.Overlap};
    assign obs[1] = {if_b.Line24, if_b.VClkPulse, if_b.nHSOut, if_b.PadCount, if_b.Overlap};
    assign obs[2] = {if_c.Line24, if_c.VClkPulse, if_c.nHSOut, if_c.PadCount, if_c.Overlap};

    pal_line_inserter u_a (
        .Clk   (Clk),
        .Reset (rst[0]),
        .bus   (if_a)
    );

    pal_line_inserter #(
        .LINE_CLKS (64),
        .HS_CLKS   (8),
        .PAD_LINES (1)
    ) u_b (
        .Clk   (Clk),
        .Reset (rst[1]),
        .bus   (if_b)
    );

    pal_line_inserter #(
        .LINE_CLKS (64),
        .HS_CLKS   (8),
        .PAD_LINES (25),
        .TOP_DELAY (2)
    ) u_c (
        .Clk   (Clk),
        .Reset (rst[2]),
        .bus   (if_c)
    );

    function automatic obs_t mk(input logic l, input logic v, input logic h,
                                input int p, input logic o);
        obs_t r;
        r.line24 = l;
        r.vclk   = v;
        r.nhsout = h;
        r.pad    = 5'(p);
        r.ovl    = o;
        return r;
    endfunction

    // Advance n clocks; leaves time 1 unit past the rising edge
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int d, input obs_t exp, input obs_t msk);
        obs_t a;
        a = obs[d];
        n_vec++;
        if (((a ^ exp) & msk) != '0) begin
            n_fail++;
            $display("FAIL %s dut%0d: got l24=%0b vclk=%0b nhs=%0b pad=%0d ovl=%0b want l24=%0b vclk=%0b nhs=%0b pad=%0d ovl=%0b mask=%b",
                     name, d, a.line24, a.vclk, a.nhsout, a.pad, a.ovl,
                     exp.line24, exp.vclk, exp.nhsout, exp.pad, exp.ovl, msk);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Clocks until the next VClkPulse on DUT d; an expired budget is a failure
    task automatic wait_pulse(input string name, input int d, input int budget, output int n);
        bit found;
        found = 1'b0;
        n     = 0;
        while (!found && n < budget) begin
            tick(1);
            n++;
            if (obs[d].vclk) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s dut%0d: no VClkPulse within %0d clocks", name, d, budget);
        end
    endtask

    vec_t vt [11];
    int   n;
    int   pulse_at;
    int   win_len;
    int   hs_lows;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]     = 1'b1;
            nhs_drv[i] = 1'b1;
            nfs_drv[i] = 1'b1;
        end

        // Bottom window on DUT a, w = clocks since Line24 rose
        vt[0]  = '{"reset_release",  0, 1,   1'b0, 1'b1, 1'b1, mk(0,0,1,0,0), M_ALL};
        vt[1]  = '{"fs_fall_lat2",   0, 2,   1'b0, 1'b1, 1'b0, mk(0,0,1,0,0), M_ALL};
        vt[2]  = '{"bot_open",       0, 1,   1'b0, 1'b1, 1'b0, mk(1,0,0,0,0), M_ALL};
        vt[3]  = '{"bot_hs_last_lo", 0, 66,  1'b0, 1'b1, 1'b0, mk(1,0,0,0,0), M_ALL};
        vt[4]  = '{"bot_hs_hi",      0, 1,   1'b0, 1'b1, 1'b0, mk(1,0,1,0,0), M_ALL};
        vt[5]  = '{"bot_nhs_ignored",0, 33,  1'b0, 1'b0, 1'b0, mk(1,0,1,0,0), M_ALL};
        vt[6]  = '{"bot_pre_pulse",  0, 810, 1'b0, 1'b1, 1'b0, mk(1,0,1,0,0), M_ALL};
        vt[7]  = '{"bot_pulse1",     0, 1,   1'b0, 1'b1, 1'b0, mk(1,1,1,1,0), M_ALL};
        vt[8]  = '{"bot_line2_start",0, 1,   1'b0, 1'b1, 1'b0, mk(1,0,0,1,0), M_ALL};
        vt[9]  = '{"bot_line2_hs_lo",0, 66,  1'b0, 1'b1, 1'b0, mk(1,0,0,1,0), M_ALL};
        vt[10] = '{"bot_line2_hs_hi",0, 1,   1'b0, 1'b1, 1'b0, mk(1,0,1,1,0), M_ALL};

        tick(3);
        chk("reset_hold", 0, mk(0,0,1,0,0), M_ALL);
        rst[1] = 1'b0;
        rst[2] = 1'b0;

        for (int i = 0; i < 11; i++) begin
            rst[vt[i].dut]     = vt[i].rst;
            nhs_drv[vt[i].dut] = vt[i].nhs;
            nfs_drv[vt[i].dut] = vt[i].nfs;
            tick(vt[i].wait_n);
            chk(vt[i].name, int'(vt[i].dut), vt[i].exp, vt[i].msk);
        end

        // Remaining bottom lines (now at w=979)
        for (int k = 2; k <= 25; k++) begin
            wait_pulse("bot_pulse", 0, 1000, n);
            chk_int("bot_gap", n, (k == 2) ? 844 : 912);
            chk("bot_pulse_pad", 0, mk(1,1,1,k,0), M_ALL);
        end
        tick(1);
        chk("bot_close", 0, mk(0,0,1,0,0), M_L24 | M_VC | M_NHS | M_OVL);

        // Top window: nFS rises, then 8 nHS falls at 912-clock spacing
        nfs_drv[0] = 1'b1;
        tick(10);
        for (int e = 1; e <= 8; e++) begin
            nhs_drv[0] = 1'b0;
            tick(2);
            if (e == 1) chk("wait_nhs_lat", 0, mk(0,0,1,0,0), M_L24 | M_NHS);
            tick(1);
            if (e < 8) chk("wait_track", 0, mk(0,0,0,0,0), M_L24 | M_VC | M_NHS);
            else       chk("top_open", 0, mk(1,0,0,0,0), M_ALL);
            tick(64);
            nhs_drv[0] = 1'b1;
            if (e < 8) tick(845);
        end
        for (int k = 1; k <= 25; k++) begin
            wait_pulse("top_pulse", 0, 1000, n);
            chk_int("top_gap", n, (k == 1) ? 847 : 912);
            chk("top_pulse_pad", 0, mk(1,1,1,k,0), M_ALL);
        end
        tick(1);
        chk("top_close", 0, mk(0,0,1,0,0), M_L24 | M_VC | M_NHS | M_OVL);
        nhs_drv[0] = 1'b0;
        tick(3);
        chk("active_track_lo", 0, mk(0,0,0,0,0), M_L24 | M_NHS);
        nhs_drv[0] = 1'b1;
        tick(3);
        chk("active_track_hi", 0, mk(0,0,1,0,0), M_L24 | M_NHS);

        // DUT b: 64-clock single-line window
        nfs_drv[1] = 1'b0;
        tick(3);
        chk("sweep_open", 1, mk(1,0,0,0,0), M_ALL);
        pulse_at = -1;
        win_len  = -1;
        hs_lows  = 1;
        for (int i = 1; i <= 200; i++) begin
            if (i == 20) nfs_drv[1] = 1'b1;
            tick(1);
            if (obs[1].vclk) begin
                pulse_at = i;
                chk("sweep_pulse", 1, mk(1,1,1,1,0), M_ALL);
            end
            if (!obs[1].line24) begin
                win_len = i;
                break;
            end
            if (!obs[1].nhsout) hs_lows++;
        end
        chk_int("sweep_pulse_at", pulse_at, 63);
        chk_int("sweep_window_len", win_len, 64);
        chk_int("sweep_hs_low_clks", hs_lows, 8);
        // nFS rose during the window, so WAIT_TOP has seen no rise: a fall reopens bottom
        nfs_drv[1] = 1'b0;
        tick(2);
        chk("wait_fall_lat", 1, mk(0,0,0,0,0), M_L24);
        tick(1);
        chk("wait_fall_no_rise", 1, mk(1,0,0,0,0), M_ALL);

        // DUT c: nFS bounce inside bottom window is ignored
        nfs_drv[2] = 1'b0;
        tick(3);
        chk("c_bot_open", 2, mk(1,0,0,0,0), M_ALL);
        for (int k = 1; k <= 25; k++) begin
            wait_pulse("c_bot_pulse", 2, 100, n);
            chk("c_bot_pulse_pad", 2, mk(1,1,1,k,0), M_ALL);
            if (k == 3) begin
                tick(5);
                nfs_drv[2] = 1'b1;
                tick(10);
                nfs_drv[2] = 1'b0;
            end
        end
        tick(1);
        chk("c_bot_close", 2, mk(0,0,0,0,0), M_L24 | M_VC | M_OVL);

        // Top window after 2 nHS falls, then field sync during line 10
        nfs_drv[2] = 1'b1;
        tick(5);
        nhs_drv[2] = 1'b0;
        tick(5);
        chk("c_wait_edge1", 2, mk(0,0,0,0,0), M_L24);
        nhs_drv[2] = 1'b1;
        tick(20);
        nhs_drv[2] = 1'b0;
        tick(3);
        chk("c_top_open", 2, mk(1,0,0,0,0), M_ALL);
        nhs_drv[2] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            wait_pulse("c_top_pulse", 2, 100, n);
            chk("c_top_pulse_pad", 2, mk(1,1,1,k,0), M_ALL);
        end
        tick(10);
        nfs_drv[2] = 1'b0;
        tick(1);
        chk("c_abort_hold1", 2, mk(1,0,0,0,0), M_L24 | M_OVL);
        tick(1);
        chk("c_abort_hold2", 2, mk(1,0,0,0,0), M_L24 | M_OVL);
        tick(1);
        chk("c_overlap_abort", 2, mk(1,0,0,0,1), M_ALL);
        for (int k = 1; k <= 25; k++) begin
            wait_pulse("c_abort_pulse", 2, 100, n);
            if (k == 1) chk_int("c_abort_gap1", n, 63);
            chk("c_abort_pulse_pad", 2, mk(1,1,1,k,1), M_ALL);
        end
        tick(1);
        chk("c_abort_close", 2, mk(0,0,0,0,1), M_L24 | M_VC | M_OVL);

        // Reopen bottom window, then reset at PadCount=12
        nfs_drv[2] = 1'b1;
        tick(5);
        nfs_drv[2] = 1'b0;
        tick(3);
        chk("c_bot_reopen", 2, mk(1,0,0,0,1), M_ALL);
        for (int k = 1; k <= 12; k++) begin
            wait_pulse("c_reopen_pulse", 2, 100, n);
        end
        tick(5);
        chk("c_pad12", 2, mk(1,0,0,12,1), M_ALL);
        rst[2]     = 1'b1;
        nfs_drv[2] = 1'b1;
        tick(1);
        chk("c_reset_mid", 2, mk(0,0,1,0,0), M_ALL);
        rst[2] = 1'b0;
        tick(3);
        nhs_drv[2] = 1'b0;
        tick(3);
        chk("c_active_track", 2, mk(0,0,0,0,0), M_ALL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
